// File: rtl/nes_joypad_target.sv
// I2C-style joypad target: answers reads of a latched pad_state snapshot, MSB first.
// Define NES_JOYPAD_TARGET_WRITE_EN to accept write transfers into ctrl_reg.
module nes_joypad_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h52,
  parameter int         NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_out,
  input  logic [8*NUM_BYTES-1:0] pad_state,
  output logic                   snapshot,
  output logic                   busy,
  output logic [7:0]             ctrl_reg
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
`ifdef NES_JOYPAD_TARGET_WRITE_EN
  localparam int SH_W = 8;
`else
  localparam int SH_W = 7;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX, TX_ACK, RX, RX_ACK, IGNORE
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [8*NUM_BYTES-1:0] buf_q, buf_d;
  logic                   sda_out_q, sda_out_d;
  logic                   snapshot_q, snapshot_d;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  logic scl_high, start_ev, stop_ev, rise_ev, fall_ev;
  assign scl_high = scl_sync_q & scl_hist_q;
  assign start_ev = scl_high & sda_hist_q & ~sda_sync_q;
  assign stop_ev  = scl_high & ~sda_hist_q & sda_sync_q;
  assign rise_ev  = scl_sync_q & ~scl_hist_q;
  assign fall_ev  = ~scl_sync_q & scl_hist_q;

  logic [7:0] addr_byte, cur_byte;
  logic       tx_bit;
  assign addr_byte = {shift_q[6:0], sda_sync_q};
  assign cur_byte  = buf_q[{byte_idx_q, 3'b000} +: 8];
  assign tx_bit    = cur_byte[3'd7 - bit_cnt_q[2:0]];

`ifdef NES_JOYPAD_TARGET_WRITE_EN
  logic [7:0] ctrl_q, ctrl_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= 8'h00;
    else        ctrl_q <= ctrl_d;
  end
  assign ctrl_reg = ctrl_q;
`else
  assign ctrl_reg = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      sda_out_q  <= 1'b1;
      snapshot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      sda_out_q  <= sda_out_d;
      snapshot_q <= snapshot_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    sda_out_d  = sda_out_q;
    snapshot_d = 1'b0;
`ifdef NES_JOYPAD_TARGET_WRITE_EN
    ctrl_d     = ctrl_q;
`endif
    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else if (stop_ev) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (rise_ev) begin
          shift_d = {shift_q[SH_W-2:0], sda_sync_q};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (addr_byte[7:1] == DEV_ADDR && addr_byte[0]) begin
              state_d    = ADDR_ACK;
              buf_d      = pad_state;
              snapshot_d = 1'b1;
              byte_idx_d = '0;
`ifdef NES_JOYPAD_TARGET_WRITE_EN
            end else if (addr_byte[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
`endif
            end else begin
              state_d = IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // First FALL drives the ACK low; the FALL after the ACK RISE ends it
        ADDR_ACK: if (fall_ev) begin
          if (bit_cnt_q == 4'd0) begin
            sda_out_d = 1'b0;
            bit_cnt_d = 4'd1;
          end else if (shift_q[0]) begin
            state_d   = TX;
            sda_out_d = cur_byte[7];
            bit_cnt_d = 4'd1;
          end else begin
`ifdef NES_JOYPAD_TARGET_WRITE_EN
            state_d   = RX;
`else
            state_d   = IGNORE;
`endif
            sda_out_d = 1'b1;
            bit_cnt_d = '0;
          end
        end
        TX: if (fall_ev) begin
          if (bit_cnt_q == 4'd8) begin
            sda_out_d = 1'b1;
            state_d   = TX_ACK;
          end else begin
            sda_out_d = tx_bit;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        TX_ACK: if (rise_ev) begin
          bit_cnt_d = '0;
          if (!sda_sync_q) begin
            state_d    = TX;
            byte_idx_d = (byte_idx_q == IDX_W'(NUM_BYTES - 1)) ? '0 : byte_idx_q + 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
`ifdef NES_JOYPAD_TARGET_WRITE_EN
        RX: if (rise_ev) begin
          shift_d = {shift_q[SH_W-2:0], sda_sync_q};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = RX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RX_ACK: if (fall_ev) begin
          if (bit_cnt_q == 4'd0) begin
            sda_out_d = 1'b0;
            bit_cnt_d = 4'd1;
          end else begin
            sda_out_d = 1'b1;
            ctrl_d    = shift_q;
            bit_cnt_d = '0;
            state_d   = RX;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign sda_out  = sda_out_q;
  assign snapshot = snapshot_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nes_joypad_target.sv
// Bit-banged initiator driving nes_joypad_target; read data checked against a byte scoreboard.
module tb_nes_joypad_target;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [31:0] pad_state = 32'hA5C3_0F81;
  logic        sda_out, snapshot, busy;
  logic [7:0]  ctrl_reg;
  logic        sda_line;

  assign sda_line = sda_m & sda_out;
  always #5 clk = ~clk;

  nes_joypad_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_out(sda_out),
    .pad_state(pad_state), .snapshot(snapshot), .busy(busy), .ctrl_reg(ctrl_reg)
  );

  int n_cmp = 0, n_err = 0;
  int snap_cnt = 0, low_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_snap;

  always @(negedge clk) begin
    if (snapshot) snap_cnt <= snap_cnt + 1;
    if (!sda_out) low_cnt <= low_cnt + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic qp();
    repeat (4) @(negedge clk);
  endtask
  task automatic hp();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qp(); scl = 1'b1; hp(); sda_m = 1'b0; hp(); scl = 1'b0; qp();
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; qp(); scl = 1'b1; hp(); sda_m = 1'b1; hp();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qp(); scl = 1'b1; hp(); scl = 1'b0; qp();
    end
    sda_m = 1'b1; qp(); scl = 1'b1; hp(); ack = sda_line; scl = 1'b0; qp();
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      qp(); scl = 1'b1; hp(); b = {b[6:0], sda_line}; scl = 1'b0; qp();
    end
    sda_m = ack_bit; qp(); scl = 1'b1; hp(); scl = 1'b0; qp(); sda_m = 1'b1;
  endtask

  // Start, address 0x52 read, n bytes (ACK each, optional NACK on last), stop
  task automatic read_txn(input string name, input int nbytes, input bit nack_last,
                          input logic [31:0] pad_after);
    logic ack;
    logic [7:0] b, e;
    int s0;
    s0 = snap_cnt;
    i2c_start();
    model_snap = pad_state;
    write_byte(8'hA5, ack);
    check_eq({name, "_addr_ack"}, 32'(ack), 32'(0));
    pad_state = pad_after;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(model_snap[(i % 4) * 8 +: 8]);
    for (int i = 0; i < nbytes; i++) begin
      read_byte((nack_last && i == nbytes - 1) ? 1'b1 : 1'b0, b);
      if (exp_q.size() == 0) begin
        check_eq({name, "_sb_underflow"}, 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s_byte%0d", name, i), 32'(b), 32'(e));
      end
    end
    check_eq({name, "_busy_mid"}, 32'(busy), 32'(1));
    i2c_stop();
    repeat (4) @(negedge clk);
    check_eq({name, "_busy_after_stop"}, 32'(busy), 32'(0));
    check_eq({name, "_snap_pulses"}, 32'(snap_cnt - s0), 32'(1));
    $display("txn %s: read %0d bytes, snapshot %h", name, nbytes, model_snap);
  endtask

  initial begin
    logic ack;
    logic [7:0] b;
    int low0, s0;

    repeat (3) @(negedge clk);
    check_eq("rst_sda_out", 32'(sda_out), 32'(1));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_snapshot", 32'(snapshot), 32'(0));
    check_eq("rst_ctrl_reg", 32'(ctrl_reg), 32'h00);
    rst_n = 1'b1;
    hp();

    read_txn("read4", 4, 1'b1, 32'hA5C3_0F81);
    read_txn("read6_wrap", 6, 1'b0, 32'hA5C3_0F81);

    low0 = low_cnt; s0 = snap_cnt;
    i2c_start();
    write_byte(8'hA7, ack);
    check_eq("wrong_addr_nack", 32'(ack), 32'(1));
    read_byte(1'b1, b);
    check_eq("wrong_addr_data", 32'(b), 32'hFF);
    check_eq("wrong_addr_busy", 32'(busy), 32'(1));
    i2c_stop();
    repeat (4) @(negedge clk);
    check_eq("wrong_addr_idle", 32'(busy), 32'(0));
    check_eq("wrong_addr_never_low", 32'(low_cnt - low0), 32'(0));
    check_eq("wrong_addr_no_snap", 32'(snap_cnt - s0), 32'(0));
    $display("txn wrong_addr: address 0x53 ignored");

    read_txn("pad_change", 4, 1'b1, 32'h0000_0000);
    read_txn("pad_zero", 4, 1'b1, 32'h0000_0000);

    pad_state = 32'hA5C3_0F81;
    i2c_start();
    write_byte(8'hA5, ack);
    check_eq("rst_mid_addr_ack", 32'(ack), 32'(0));
    qp(); scl = 1'b1; hp(); scl = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rst_mid_driving_low", 32'(sda_out), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_release", 32'(sda_out), 32'(1));
    check_eq("rst_mid_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    qp(); scl = 1'b1; hp();
    $display("txn reset_mid_read: reset applied during data bit");
    read_txn("post_reset", 1, 1'b1, 32'hA5C3_0F81);

    i2c_start();
    write_byte(8'hA4, ack);
`ifdef NES_JOYPAD_TARGET_WRITE_EN
    check_eq("write_addr_ack", 32'(ack), 32'(0));
    write_byte(8'h3C, ack);
    check_eq("write_data_ack", 32'(ack), 32'(0));
    i2c_stop();
    repeat (4) @(negedge clk);
    check_eq("write_ctrl_reg", 32'(ctrl_reg), 32'h3C);
`else
    check_eq("write_addr_nack", 32'(ack), 32'(1));
    write_byte(8'h3C, ack);
    check_eq("write_data_nack", 32'(ack), 32'(1));
    i2c_stop();
    repeat (4) @(negedge clk);
    check_eq("write_ctrl_reg", 32'(ctrl_reg), 32'h00);
`endif
    check_eq("write_busy_after_stop", 32'(busy), 32'(0));
    $display("txn write: ctrl_reg=%h", ctrl_reg);

    check_eq("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
